// File: rtl/tdm_demultiplexer_if.sv
// Bundle of the lane inputs and channel outputs of the TDM demultiplexer.
// The master side drives the serial lane and watches the channel outputs.
// The slave side is the demultiplexer itself.
interface tdm_demultiplexer_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic             sync;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic             address0;
    logic             address1;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;

    modport master (
        output en, sync, din,
        input  out0, out1, out2, out3,
        input  address0, address1, frame_valid, locked, sync_err
    );

    modport slave (
        input  en, sync, din,
        output out0, out1, out2, out3,
        output address0, address1, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// Four-channel time-division demultiplexer.
// Follows the slot position on a shared lane and collects slots 0..2 in a shadow register.
// On a clean slot-3 word it publishes the whole frame at once and pulses frame_valid.
// A sync marker in the wrong slot aborts the frame and pulses sync_err.
// Sync missing at slot 0 also drops lock and sends the block back to hunting.
module tdm_demultiplexer #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdm_demultiplexer_if.slave   bus
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [WIDTH-1:0] shadow0;
    logic [WIDTH-1:0] shadow1;
    logic [WIDTH-1:0] shadow2;

    // Address and lock flag come straight from registers, so no input reaches them combinationally
    assign bus.address0 = slot[0];
    assign bus.address1 = slot[1];
    assign bus.locked   = (state == LOCKED);

    // Framing state machine: slot tracking, shadow capture, frame publish and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= HUNT;
            slot            <= 2'd0;
            shadow0         <= '0;
            shadow1         <= '0;
            shadow2         <= '0;
            bus.out0        <= '0;
            bus.out1        <= '0;
            bus.out2        <= '0;
            bus.out3        <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
            if (bus.en) begin
                case (state)
                    HUNT: begin
                        if (bus.sync) begin
                            shadow0 <= bus.din;
                            slot    <= 2'd1;
                            state   <= LOCKED;
                        end else begin
                            slot    <= 2'd0;
                        end
                    end
                    LOCKED: begin
                        if (slot == 2'd0) begin
                            if (bus.sync) begin
                                shadow0 <= bus.din;
                                slot    <= 2'd1;
                            end else begin
                                bus.sync_err <= 1'b1;
                                slot         <= 2'd0;
                                state        <= HUNT;
                            end
                        end else if (bus.sync) begin
                            bus.sync_err <= 1'b1;
                            shadow0      <= bus.din;
                            slot         <= 2'd1;
                        end else begin
                            case (slot)
                                2'd1: begin
                                    shadow1 <= bus.din;
                                    slot    <= 2'd2;
                                end
                                2'd2: begin
                                    shadow2 <= bus.din;
                                    slot    <= 2'd3;
                                end
                                default: begin
                                    bus.out0        <= shadow0;
                                    bus.out1        <= shadow1;
                                    bus.out2        <= shadow2;
                                    bus.out3        <= bus.din;
                                    bus.frame_valid <= 1'b1;
                                    slot            <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state <= HUNT;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Testbench for tdm_demultiplexer: directed test-plan sequences followed by randomized traffic.
// The reference model tracks lock plus a queue of words gathered for the current frame.
module tb_tdm_demultiplexer;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    tdm_demultiplexer_if #(.WIDTH(W)) busIf ();

    tdm_demultiplexer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    int total;
    int bad;

    // Reference model state
    bit           mLocked;
    logic [W-1:0] partial[$];
    logic [W-1:0] mOut[4];
    bit           mFv;
    bit           mErr;

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mLocked = 1'b0;
        partial.delete();
        for (int i = 0; i < 4; i++) mOut[i] = '0;
        mFv  = 1'b0;
        mErr = 1'b0;
    endtask

    // One lane sample interpreted directly from the framing rules
    task automatic modelStep(input bit en, input bit sync, input logic [W-1:0] d);
        mFv  = 1'b0;
        mErr = 1'b0;
        if (!en) return;
        if (!mLocked) begin
            if (sync) begin
                partial.delete();
                partial.push_back(d);
                mLocked = 1'b1;
            end
        end else if (partial.size() == 0) begin
            if (sync) begin
                partial.push_back(d);
            end else begin
                mErr    = 1'b1;
                mLocked = 1'b0;
            end
        end else if (sync) begin
            mErr = 1'b1;
            partial.delete();
            partial.push_back(d);
        end else if (partial.size() == 3) begin
            for (int i = 0; i < 3; i++) mOut[i] = partial[i];
            mOut[3] = d;
            mFv     = 1'b1;
            partial.delete();
        end else begin
            partial.push_back(d);
        end
    endtask

    task automatic checkAll(input string ctx);
        checkOutput({ctx, ".out0"}, 32'(busIf.out0), 32'(mOut[0]));
        checkOutput({ctx, ".out1"}, 32'(busIf.out1), 32'(mOut[1]));
        checkOutput({ctx, ".out2"}, 32'(busIf.out2), 32'(mOut[2]));
        checkOutput({ctx, ".out3"}, 32'(busIf.out3), 32'(mOut[3]));
        checkOutput({ctx, ".addr"}, 32'({busIf.address1, busIf.address0}), 32'(partial.size()));
        checkOutput({ctx, ".frame_valid"}, 32'(busIf.frame_valid), 32'(mFv));
        checkOutput({ctx, ".locked"}, 32'(busIf.locked), 32'(mLocked));
        checkOutput({ctx, ".sync_err"}, 32'(busIf.sync_err), 32'(mErr));
    endtask

    // Drive one cycle on the lane, then check every output shortly after the rising edge
    task automatic applyStimulus(input string ctx, input bit en, input bit sync, input logic [W-1:0] d);
        @(negedge clk);
        busIf.en   = en;
        busIf.sync = sync;
        busIf.din  = d;
        @(posedge clk);
        #2;
        modelStep(en, sync, d);
        checkAll(ctx);
    endtask

    task automatic sendFrame(input string ctx, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] e);
        applyStimulus(ctx, 1'b1, 1'b1, a);
        applyStimulus(ctx, 1'b1, 1'b0, b);
        applyStimulus(ctx, 1'b1, 1'b0, c);
        applyStimulus(ctx, 1'b1, 1'b0, e);
    endtask

    // Directed test-plan sequences, then randomized traffic
    initial begin
        bit           en;
        bit           sync;
        logic [W-1:0] d;

        total = 0;
        bad   = 0;
        busIf.en   = 1'b0;
        busIf.sync = 1'b0;
        busIf.din  = '0;
        rst_n      = 1'b0;
        modelReset();

        #1;
        checkAll("reset_async");
        repeat (2) begin
            @(posedge clk);
            #2;
            checkAll("reset_held");
        end

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("idle", 1'b0, 1'b0, '0);

        sendFrame("single", 4'd1, 4'd0, 4'd1, 4'd1);

        sendFrame("b2b_a", 4'd1, 4'd1, 4'd0, 4'd0);
        sendFrame("b2b_b", 4'd0, 4'd1, 4'd0, 4'd1);

        applyStimulus("gap", 1'b1, 1'b1, 4'd0);
        applyStimulus("gap", 1'b0, 1'b0, 4'd7);
        applyStimulus("gap", 1'b1, 1'b0, 4'd1);
        applyStimulus("gap", 1'b0, 1'b1, 4'd9);
        applyStimulus("gap", 1'b1, 1'b0, 4'd1);
        applyStimulus("gap", 1'b0, 1'b0, 4'd3);
        applyStimulus("gap", 1'b1, 1'b0, 4'd0);

        applyStimulus("realign", 1'b1, 1'b1, 4'd1);
        applyStimulus("realign", 1'b1, 1'b0, 4'd1);
        applyStimulus("realign", 1'b1, 1'b1, 4'd0);
        applyStimulus("realign", 1'b1, 1'b0, 4'd1);
        applyStimulus("realign", 1'b1, 1'b0, 4'd1);
        applyStimulus("realign", 1'b1, 1'b0, 4'd1);

        sendFrame("lol_frame", 4'd5, 4'd6, 4'd7, 4'd8);
        applyStimulus("lol", 1'b1, 1'b0, 4'd3);
        applyStimulus("hunt", 1'b1, 1'b0, 4'd2);

        sendFrame("pre_rst", 4'd9, 4'd10, 4'd11, 4'd12);
        applyStimulus("pre_rst", 1'b1, 1'b1, 4'd4);
        applyStimulus("pre_rst", 1'b1, 1'b0, 4'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("midframe_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_rst", 1'b1, 1'b0, 4'd6);
        sendFrame("post_rst", 4'd3, 4'd2, 4'd1, 4'd15);

        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 9) < 8);
            sync = (mLocked ? (partial.size() == 0) : ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 11) == 0) sync = ~sync;
            d = W'($urandom);
            applyStimulus("rand", en, sync, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
